microstep_sequencer: RTL and testbench
======================================

# microstep_sequencer

Sequencer that owns the microstep counter feeding the instruction decoder's `i_step` input. It closes the loop on the decoder's `c_ADV` and `c_HLT` control bits, gates datapath register updates in free-run or single-step mode, and stops the machine on halt or on a runaway instruction. It sits between the front-panel/clock controls and the decoder/datapath, and counts retired instructions for the status display.

## Interface
- `INSTRUCTION_STEPS`, default 8: microsteps per instruction slot. Must be a power of two and at least 4. `STEP_WIDTH = $clog2(INSTRUCTION_STEPS)`.
- `COUNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_reset`, in, 1: reset, asynchronous and active-high.
- `i_run_mode`, in, 1: 1 = free-run, 0 = single-step. Synchronous to `i_clk`.
- `i_step_btn`, in, 1: single-step button level. Already synchronised and debounced upstream.
- `i_resume`, in, 1: leave HALTED. Level; only sampled in HALTED.
- `i_adv`, in, 1: `c_ADV` bit of the current decoder control word.
- `i_hlt`, in, 1: `c_HLT` bit of the current decoder control word.
- `o_step`, out, `STEP_WIDTH`: current microstep, drives decoder `i_step`.
- `o_fire`, out, 1: datapath registers and PC commit the current control word on this rising edge.
- `o_halted`, out, 1: state is HALTED.
- `o_fault`, out, 1: state is FAULT (sticky).
- `o_instr_count`, out, `COUNT_WIDTH`: instructions retired via `i_adv`.

## Operation
States: RUN, HALTED, FAULT.

Edge detect:
- Register `btn_q <= i_step_btn`; reset value 0.
- `step_edge = i_step_btn & ~btn_q`.

Fire:
- `o_fire = (state==RUN) & (i_run_mode | step_edge)`. Combinational.
- No fire ever occurs in HALTED or FAULT.

On a fire cycle, priority top-down:
1. `i_hlt` → state becomes HALTED. `o_step` holds. Count is unchanged.
2. `i_adv` → `o_step` becomes 0 and `o_instr_count` increments (wraps modulo 2^`COUNT_WIDTH`).
3. `o_step == INSTRUCTION_STEPS-1` → state becomes FAULT and `o_step` holds.
4. Otherwise `o_step` increments by 1.

When `i_hlt` and `i_adv` are asserted together, halt wins and the count does not increment.

Non-fire cycle in RUN: all state holds.

HALTED:
- `i_resume`=1 → state becomes RUN and `o_step` becomes 0. The PC already advanced at step 1, so execution continues at the next instruction.
- After resume in single-step mode, the next fire still requires a button edge.

FAULT:
- Sticky. Only `i_reset` leaves it.
- `i_resume` and `i_step_btn` are ignored.

`i_run_mode` may change on any cycle and takes effect on that same cycle's `o_fire`. A button edge in free-run mode has no extra effect.

Reset (asynchronous, any state, mid-instruction included):
- `o_step`=0, state=RUN, `o_halted`=0, `o_fault`=0, `o_instr_count`=0, `btn_q`=0.
- If `i_step_btn` is high at reset release, this yields one fire in single-step mode. This is accepted behaviour.

## Timing
- All state updates happen on the rising edge of `i_clk`. `o_step`, `o_halted`, `o_fault` and `o_instr_count` are registered.
- `o_fire` is combinational from state, `i_run_mode`, `i_step_btn` and `btn_q`. `i_adv` and `i_hlt` do not affect `o_fire`, so there is no loop through the decoder.
- Free-run throughput: one microstep per cycle. An instruction ending in ADV at step k occupies k+1 cycles; `o_step` is 0 on the cycle after the ADV fire.
- Single-step: exactly one fire per 0→1 transition of `i_step_btn`, in the cycle the new level is first seen. A held button gives no repeat.
- HALTED is visible on `o_halted` the cycle after the HLT fire. Resume takes effect one cycle after `i_resume` is sampled.
- FAULT is asserted the cycle after the overflowing fire.

## Test plan
- Free-run with ADV at step 3 (LDA-like): `o_step` sequence 0,1,2,3,0,1… One increment of `o_instr_count` per 4 cycles; `o_fire`=1 every cycle.
- Single-step: hold `i_run_mode`=0, button high for 5 cycles, then low, then high again. Exactly 2 fires; `o_step` goes 0→1→2; no fire while the button is held.
- HLT at step 2 with `i_adv`=1 simultaneously: `o_halted`=1 next cycle, `o_step`=2, count unchanged, `o_fire`=0 thereafter. Assert `i_resume`: `o_step`=0, RUN, firing resumes.
- Runaway: `i_adv`=`i_hlt`=0 forever. After 8 fires, `o_fault`=1 with `o_step`=7. Resume and button edges have no effect until `i_reset`.
- Counter wrap with `COUNT_WIDTH`=4: after 16 ADV fires `o_instr_count` reads 0, and no fault occurs.
- Async reset asserted mid-cycle at step 3 while HALTED: all outputs return to reset values immediately, without waiting for a clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/microstep_sequencer_if.sv
// Control/status bundle between the front panel, decoder and the microstep sequencer.
// The master side drives the panel and decoder bits; the slave side is the sequencer.
interface microstep_sequencer_if #(
    parameter int STEP_WIDTH  = 3,
    parameter int COUNT_WIDTH = 16
);
    logic                   i_run_mode;
    logic                   i_step_btn;
    logic                   i_resume;
    logic                   i_adv;
    logic                   i_hlt;
    logic [STEP_WIDTH-1:0]  o_step;
    logic                   o_fire;
    logic                   o_halted;
    logic                   o_fault;
    logic [COUNT_WIDTH-1:0] o_instr_count;

    modport master (
        output i_run_mode, i_step_btn, i_resume, i_adv, i_hlt,
        input  o_step, o_fire, o_halted, o_fault, o_instr_count
    );

    modport slave (
        input  i_run_mode, i_step_btn, i_resume, i_adv, i_hlt,
        output o_step, o_fire, o_halted, o_fault, o_instr_count
    );
endinterface

// File: rtl/microstep_sequencer.sv
// Owns the decoder microstep counter: fires the datapath in free-run or single-step mode,
// stops on HLT or on a runaway instruction, and counts retired instructions.
module microstep_sequencer #(
    parameter int INSTRUCTION_STEPS = 8,
    parameter int COUNT_WIDTH       = 16
) (
    input logic                 i_clk,
    input logic                 i_reset,
    microstep_sequencer_if.slave bus
);
    localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS);

    localparam logic [STEP_WIDTH-1:0]  LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);
    localparam logic [STEP_WIDTH-1:0]  STEP_ONE  = STEP_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    // Encoded so that the halted/fault status outputs are register bits directly.
    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_HALTED = 2'b01;
    localparam logic [1:0] ST_FAULT  = 2'b10;

    logic [1:0]             state;
    logic [STEP_WIDTH-1:0]  step_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   btn_q;
    logic                   step_edge;
    logic                   fire;

    // Fire does not depend on adv/hlt, so there is no combinational loop through the decoder.
    assign step_edge = bus.i_step_btn & ~btn_q;
    assign fire      = (state == ST_RUN) & (bus.i_run_mode | step_edge);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_RUN;
            step_q  <= '0;
            count_q <= '0;
            btn_q   <= 1'b0;
        end else begin
            btn_q <= bus.i_step_btn;
            case (state)
                ST_RUN: begin
                    if (fire) begin
                        if (bus.i_hlt) begin
                            state <= ST_HALTED;
                        end else if (bus.i_adv) begin
                            step_q  <= '0;
                            count_q <= count_q + COUNT_ONE;
                        end else if (step_q == LAST_STEP) begin
                            state <= ST_FAULT;
                        end else begin
                            step_q <= step_q + STEP_ONE;
                        end
                    end
                end
                ST_HALTED: begin
                    // PC already advanced at step 1, so resuming restarts at step 0 of the next instruction.
                    if (bus.i_resume) begin
                        state  <= ST_RUN;
                        step_q <= '0;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign bus.o_step        = step_q;
    assign bus.o_fire        = fire;
    assign bus.o_halted      = state[0];
    assign bus.o_fault       = state[1];
    assign bus.o_instr_count = count_q;
endmodule

// File: tb/tb_microstep_sequencer.sv
// Self-checking bench for microstep_sequencer: vector table plus hand-written corner sequences,
// with expected results passed through a scoreboard queue.
module tb_microstep_sequencer;
    localparam int STEPS = 8;
    localparam int SW    = 3;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    microstep_sequencer_if #(.STEP_WIDTH(SW), .COUNT_WIDTH(CW)) bus ();

    microstep_sequencer #(
        .INSTRUCTION_STEPS(STEPS),
        .COUNT_WIDTH(CW)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic          run_mode;
        logic          step_btn;
        logic          resume;
        logic          adv;
        logic          hlt;
        logic          exp_fire;
        logic [SW-1:0] exp_step;
        logic          exp_halted;
        logic          exp_fault;
        logic [CW-1:0] exp_count;
    } vec_t;

    typedef struct packed {
        logic          fire;
        logic [SW-1:0] step;
        logic          halted;
        logic          fault;
        logic [CW-1:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_value(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        bus.i_run_mode = v.run_mode;
        bus.i_step_btn = v.step_btn;
        bus.i_resume   = v.resume;
        bus.i_adv      = v.adv;
        bus.i_hlt      = v.hlt;
        e.fire   = v.exp_fire;
        e.step   = v.exp_step;
        e.halted = v.exp_halted;
        e.fault  = v.exp_fault;
        e.count  = v.exp_count;
        sb_q.push_back(e);
    endtask

    // Fire is sampled mid-cycle before the edge; registered outputs #1 after it.
    task automatic check_output(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            @(posedge clk);
            #1;
        end else begin
            e = sb_q.pop_front();
            #1;
            check_value({tag, " fire"}, int'(bus.o_fire), int'(e.fire));
            @(posedge clk);
            #1;
            check_value({tag, " step"},   int'(bus.o_step),        int'(e.step));
            check_value({tag, " halted"}, int'(bus.o_halted),      int'(e.halted));
            check_value({tag, " fault"},  int'(bus.o_fault),       int'(e.fault));
            check_value({tag, " count"},  int'(bus.o_instr_count), int'(e.count));
        end
    endtask

    task automatic run_cycle(input string tag,
                             input logic rm, input logic btn, input logic res,
                             input logic adv, input logic hlt,
                             input logic fire, input logic [SW-1:0] step,
                             input logic halted, input logic fault, input logic [CW-1:0] count);
        vec_t v;
        v = '{rm, btn, res, adv, hlt, fire, step, halted, fault, count};
        apply_stimulus(v);
        check_output(tag);
    endtask

    task automatic do_reset();
        bus.i_run_mode = 1'b0;
        bus.i_step_btn = 1'b0;
        bus.i_resume   = 1'b0;
        bus.i_adv      = 1'b0;
        bus.i_hlt      = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[22];

    initial begin
        // run_mode, btn, resume, adv, hlt | fire, step, halted, fault, count
        // Free-run, ADV at step 3.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 4'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd2};
        // Single-step: held button fires once, release and re-press fires again.
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 4'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 4'd2};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 4'd2};
        // HLT together with ADV at step 2, then resume.
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 4'd2};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 4'd2};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd2};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd2};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd3};

        bus.i_run_mode = 1'b0;
        bus.i_step_btn = 1'b0;
        bus.i_resume   = 1'b0;
        bus.i_adv      = 1'b0;
        bus.i_hlt      = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset step",   int'(bus.o_step),        0);
        check_value("reset halted", int'(bus.o_halted),      0);
        check_value("reset fault",  int'(bus.o_fault),       0);
        check_value("reset count",  int'(bus.o_instr_count), 0);
        check_value("reset fire",   int'(bus.o_fire),        0);
        rst = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i));
        end

        $display("[TB] runaway instruction");
        do_reset();
        for (int i = 1; i < 8; i++)
            run_cycle($sformatf("runaway%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b1, 3'(i), 1'b0, 1'b0, 4'd0);
        run_cycle("runaway overflow", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 4'd0);
        run_cycle("fault resume",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 4'd0);
        run_cycle("fault btn up",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 4'd0);
        run_cycle("fault btn down",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 4'd0);
        run_cycle("fault btn resume", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 4'd0);
        do_reset();
        #1;
        check_value("fault cleared", int'(bus.o_fault), 0);
        check_value("fault step",    int'(bus.o_step),  0);
        @(posedge clk);
        #1;

        $display("[TB] counter wrap");
        do_reset();
        for (int i = 1; i <= 16; i++)
            run_cycle($sformatf("wrap%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                      1'b1, 3'd0, 1'b0, 1'b0, 4'(i % 16));

        $display("[TB] async reset while halted");
        do_reset();
        run_cycle("pre adv",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd1);
        run_cycle("pre s1",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd1);
        run_cycle("pre s2",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 4'd1);
        run_cycle("pre s3",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'd1);
        run_cycle("pre hlt",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 4'd1);
        run_cycle("pre hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 4'd1);
        bus.i_run_mode = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_value("async step",   int'(bus.o_step),        0);
        check_value("async halted", int'(bus.o_halted),      0);
        check_value("async fault",  int'(bus.o_fault),       0);
        check_value("async count",  int'(bus.o_instr_count), 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_cycle("post reset s1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd0);
        run_cycle("post reset adv", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd1);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
